transceiver_top: RTL and testbench

- Self-contained serial loopback transceiver.
- Collects 8 serial input bits into a byte and Hamming(12,8)-encodes it.
- Transmits the codeword as 12 antipodal (BPSK-style) 12-bit samples, hard-demodulates them back, and corrects any single-bit error.
- Presents the recovered byte with a one-cycle done pulse. Intended as a top-level link demo and verification vehicle.

---
 rtl/transceiver_top.sv | 141 ++++++++++++++
 tb/tb_transceiver_top.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/transceiver_top.sv
// Serial loopback transceiver: collects a byte MSB first, Hamming(12,8)
// encodes it, sends the codeword as antipodal 12-bit samples, hard-demodulates
// them back, corrects a single-bit error, and reports the recovered byte.
module transceiver_top #(
  parameter int AMP     = 2047,
  parameter int ERR_POS = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        data,
  output logic        done,
  output logic        q,
  output logic [11:0] modulator_out
);

  typedef enum logic [1:0] {COLLECT, ENC, TX, DEC} state_t;

  // Handshake: there is none; en is a plain qualifier that is honoured only
  // in COLLECT, and done is a one-cycle strobe with decoder_out held after it.

  localparam logic [11:0] POS_SAMPLE = 12'(AMP);
  localparam logic [11:0] NEG_SAMPLE = 12'(-AMP);

  state_t      state;
  state_t      state_next;
  logic [2:0]  bit_cnt;
  logic [7:0]  byte_reg;
  logic [11:0] encoder_out;
  logic [11:0] rx_shift;
  logic [7:0]  decoder_out;
  logic [3:0]  tx_cnt;

  logic [3:0]  tx_pos;
  logic        tx_bit;
  logic [11:0] tx_sample;
  logic        decision;
  logic [3:0]  syndrome;
  logic [11:0] corrected;
  logic        unused_probe;

  // Hamming(12,8): data sits at c3,c5,c6,c7,c9..c12; parity at powers of two.
  function automatic logic [11:0] hamming(input logic [7:0] d);
    logic p1, p2, p4, p8;
    p1 = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
    p2 = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
    p4 = d[1] ^ d[2] ^ d[3] ^ d[7];
    p8 = d[4] ^ d[5] ^ d[6] ^ d[7];
    return {d[7], d[6], d[5], d[4], p8, d[3], d[2], d[1], p4, d[0], p2, p1};
  endfunction

  // Transmit side: codeword position sent this cycle is c(12 - tx_cnt).
  always_comb begin
    tx_pos    = 4'd12 - tx_cnt;
    tx_bit    = 1'b0;
    if (tx_cnt < 4'd12) tx_bit = encoder_out[4'd11 - tx_cnt];
    if ((ERR_POS != 0) && (int'(tx_pos) == ERR_POS)) tx_bit = ~tx_bit;
    tx_sample = tx_bit ? POS_SAMPLE : NEG_SAMPLE;
    decision  = ~modulator_out[11];
  end

  // Receive side: syndrome over the collected codeword and single-bit fix.
  always_comb begin
    syndrome[0] = ^(rx_shift & 12'h555);
    syndrome[1] = ^(rx_shift & 12'h666);
    syndrome[2] = ^(rx_shift & 12'h878);
    syndrome[3] = ^(rx_shift & 12'hF80);
    corrected   = rx_shift;
    if ((syndrome != 4'd0) && (syndrome <= 4'd12))
      corrected = rx_shift ^ (12'd1 << (syndrome - 4'd1));
  end

  // decoder_out is a probe-only net; fold it into a sink so it counts as read.
  assign unused_probe = ^decoder_out;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= COLLECT;
    else     state <= state_next;
  end

  // Next-state logic for the frame sequence.
  always_comb begin
    state_next = state;
    case (state)
      COLLECT: if (en && (bit_cnt == 3'd7)) state_next = ENC;
      ENC:     state_next = TX;
      TX:      if (tx_cnt == 4'd12) state_next = DEC;
      DEC:     state_next = COLLECT;
      default: state_next = COLLECT;
    endcase
  end

  // Datapath: byte collection, encoding, modulation, demodulation, decoding.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt       <= 3'd0;
      byte_reg      <= 8'd0;
      encoder_out   <= 12'd0;
      rx_shift      <= 12'd0;
      decoder_out   <= 8'd0;
      tx_cnt        <= 4'd0;
      modulator_out <= 12'd0;
      q             <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        COLLECT: begin
          if (en) begin
            byte_reg <= {byte_reg[6:0], data};
            bit_cnt  <= bit_cnt + 3'd1;
          end
        end
        ENC: begin
          encoder_out <= hamming(byte_reg);
          tx_cnt      <= 4'd0;
        end
        TX: begin
          if (tx_cnt != 4'd12) begin
            modulator_out <= tx_sample;
            tx_cnt        <= tx_cnt + 4'd1;
          end else begin
            modulator_out <= 12'd0;
          end
          // Each sample is sliced one cycle after it is launched.
          if (tx_cnt != 4'd0) begin
            q        <= decision;
            rx_shift <= {rx_shift[10:0], decision};
          end
        end
        DEC: begin
          decoder_out <= {corrected[11:8], corrected[6:4], corrected[2]};
          done        <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_transceiver_top.sv
// Bench for transceiver_top: three instances (no error, error at c5, error
// at c12) share the same stimulus and are checked against a position-based
// Hamming model and the expected sample/decision stream.
module tb_transceiver_top;

  logic clk = 1'b0;
  logic rst, en, data;

  logic        done_w[3];
  logic        q_w[3];
  logic [11:0] mod_w[3];
  logic [11:0] enc_w[3];
  logic [7:0]  dec_w[3];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  logic last_q[3];
  int err_pos_tab[3];

  // Clock generation.
  always #5 clk = ~clk;

  transceiver_top #(.AMP(2047), .ERR_POS(0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .data(data),
    .done(done_w[0]), .q(q_w[0]), .modulator_out(mod_w[0]));
  transceiver_top #(.AMP(2047), .ERR_POS(5)) dut5 (
    .clk(clk), .rst(rst), .en(en), .data(data),
    .done(done_w[1]), .q(q_w[1]), .modulator_out(mod_w[1]));
  transceiver_top #(.AMP(2047), .ERR_POS(12)) dut12 (
    .clk(clk), .rst(rst), .en(en), .data(data),
    .done(done_w[2]), .q(q_w[2]), .modulator_out(mod_w[2]));

  assign enc_w[0] = dut0.encoder_out;
  assign enc_w[1] = dut5.encoder_out;
  assign enc_w[2] = dut12.encoder_out;
  assign dec_w[0] = dut0.decoder_out;
  assign dec_w[1] = dut5.decoder_out;
  assign dec_w[2] = dut12.decoder_out;

  // Reference encoder: data fills non-power-of-two positions in order; each
  // parity bit 2^j covers every position with bit j set.
  function automatic logic [11:0] ref_encode(input logic [7:0] d);
    logic [12:0] c;
    int di;
    logic par;
    c  = '0;
    di = 0;
    for (int p = 1; p <= 12; p++)
      if ((p & (p - 1)) != 0) begin
        c[p] = d[di];
        di++;
      end
    for (int j = 0; j < 4; j++) begin
      par = 1'b0;
      for (int p = 1; p <= 12; p++)
        if (((p & (p - 1)) != 0) && ((p & (1 << j)) != 0)) par ^= c[p];
      c[1 << j] = par;
    end
    return c[12:1];
  endfunction

  function automatic logic [11:0] ref_sample(input logic b);
    logic [11:0] amp;
    amp = 12'd2047;
    return b ? amp : (~amp + 12'd1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // One full frame: bits (optionally with an en gap), then every output of
  // every instance through ENC, TX and DEC.
  task automatic run_frame(input logic [7:0] b, input int gap_at, input int gap_len);
    logic [11:0] cw;
    logic eff;
    int t_first;
    cw = ref_encode(b);
    t_first = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == gap_at)
        for (int g = 0; g < gap_len; g++) begin
          en = 1'b0; data = 1'($urandom);
          tick();
        end
      en = 1'b1; data = b[7 - i];
      tick();
      if (i == 0) t_first = cyc;
      for (int d = 0; d < 3; d++) begin
        n_cmp++;
        if (done_w[d] !== 1'b0) begin
          n_bad++;
          $display("FAIL collect_done dut%0d bit%0d got=%b exp=0", d, i, done_w[d]);
        end
      end
    end
    en = 1'($urandom); data = 1'($urandom);
    tick();
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if (enc_w[d] !== cw) begin
        n_bad++;
        $display("FAIL encoder_out dut%0d byte=%h got=%h exp=%h", d, b, enc_w[d], cw);
      end
    end
    for (int k = 0; k < 12; k++) begin
      en = 1'($urandom); data = 1'($urandom);
      tick();
      for (int d = 0; d < 3; d++) begin
        eff = cw[11 - k] ^ (err_pos_tab[d] == 12 - k);
        n_cmp++;
        if (mod_w[d] !== ref_sample(eff)) begin
          n_bad++;
          $display("FAIL tx_sample dut%0d pos=c%0d got=%h exp=%h", d, 12 - k, mod_w[d], ref_sample(eff));
        end
        n_cmp++;
        if (q_w[d] !== last_q[d]) begin
          n_bad++;
          $display("FAIL q dut%0d step%0d got=%b exp=%b", d, k, q_w[d], last_q[d]);
        end
        last_q[d] = eff;
      end
    end
    en = 1'($urandom); data = 1'($urandom);
    tick();
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if (mod_w[d] !== 12'd0 || q_w[d] !== last_q[d] || done_w[d] !== 1'b0) begin
        n_bad++;
        $display("FAIL tx_end dut%0d got mod=%h q=%b done=%b exp mod=000 q=%b done=0",
                 d, mod_w[d], q_w[d], done_w[d], last_q[d]);
      end
    end
    en = 1'($urandom); data = 1'($urandom);
    tick();
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if (done_w[d] !== 1'b1 || dec_w[d] !== b) begin
        n_bad++;
        $display("FAIL decode dut%0d got done=%b byte=%h exp done=1 byte=%h", d, done_w[d], dec_w[d], b);
      end
    end
    n_cmp++;
    if (cyc - t_first !== 22 + gap_len) begin
      n_bad++;
      $display("FAIL latency got=%0d exp=%0d", cyc - t_first, 22 + gap_len);
    end
    en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; data = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if (done_w[d] !== 1'b0 || q_w[d] !== 1'b0 || mod_w[d] !== 12'd0 ||
          enc_w[d] !== 12'd0 || dec_w[d] !== 8'd0) begin
        n_bad++;
        $display("FAIL reset dut%0d got done=%b q=%b mod=%h enc=%h dec=%h exp all 0",
                 d, done_w[d], q_w[d], mod_w[d], enc_w[d], dec_w[d]);
      end
      last_q[d] = 1'b0;
    end
    rst = 1'b0;
  endtask

  task automatic test_byte_ff();
    run_frame(8'hFF, -1, 0);
    n_cmp++;
    if (enc_w[0] !== 12'hF77) begin
      n_bad++;
      $display("FAIL codeword_ff got=%h exp=f77", enc_w[0]);
    end
    tick();
  endtask

  task automatic test_byte_00();
    run_frame(8'h00, -1, 0);
    n_cmp++;
    if (enc_w[0] !== 12'h000) begin
      n_bad++;
      $display("FAIL codeword_00 got=%h exp=000", enc_w[0]);
    end
    tick();
    n_cmp++;
    if (done_w[0] !== 1'b0 || dec_w[0] !== 8'h00) begin
      n_bad++;
      $display("FAIL done_pulse got done=%b dec=%h exp done=0 dec=00", done_w[0], dec_w[0]);
    end
  endtask

  task automatic test_en_gap();
    run_frame(8'hA5, 4, 5);
    tick();
  endtask

  task automatic test_error_injection();
    run_frame(8'h3C, -1, 0);
    tick();
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 100; n++) run_frame(8'($urandom_range(0, 255)), -1, 0);
    tick();
  endtask

  task automatic test_reset_mid_tx();
    logic [7:0] b;
    b = 8'($urandom_range(0, 255));
    for (int i = 0; i < 8; i++) begin
      en = 1'b1; data = b[7 - i];
      tick();
    end
    en = 1'b1; data = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; en = 1'b0;
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if (done_w[d] !== 1'b0 || q_w[d] !== 1'b0 || mod_w[d] !== 12'd0 ||
          enc_w[d] !== 12'd0 || dec_w[d] !== 8'd0) begin
        n_bad++;
        $display("FAIL reset_mid_tx dut%0d got done=%b q=%b mod=%h enc=%h dec=%h exp all 0",
                 d, done_w[d], q_w[d], mod_w[d], enc_w[d], dec_w[d]);
      end
      last_q[d] = 1'b0;
    end
    run_frame(8'h96, -1, 0);
    tick();
  endtask

  // Test sequence.
  initial begin
    err_pos_tab[0] = 0;
    err_pos_tab[1] = 5;
    err_pos_tab[2] = 12;
    rst = 1'b1; en = 1'b0; data = 1'b0;
    test_reset();
    test_byte_ff();
    test_byte_00();
    test_en_gap();
    test_error_injection();
    test_back_to_back();
    test_reset_mid_tx();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
